// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute control FSM for the 4-bit-address
// instruction path. It steps the external program counter, latches the
// instruction word and issues the accumulator/ALU strobes. It also resolves
// the JMP and JZ branches.
//
// Ports:
//   clk          system clock, all state updates on posedge
//   rst_n        asynchronous active-low reset
//   i_start      leave IDLE/HALT and begin fetching
//   i_instr      instruction word at the current instruction memory address
//   i_mem_ready  i_instr is valid this cycle
//   i_zero       accumulator-zero flag, sampled during EXEC only
//   o_incPC      increment program counter
//   o_loadPC     load program counter from o_selPC
//   o_selPC      branch target, zero-extended ir operand
//   o_ir         registered instruction register
//   o_alu_op     00 pass-immediate, 01 add, 10 sub
//   o_acc_we     accumulator write enable
//   o_halted     high while in HALT
//   o_busy       high in FETCH, DECODE or EXEC
module pc_sequencer #(
  parameter int unsigned IW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [IW-1:0] i_instr,
  input  logic          i_mem_ready,
  input  logic          i_zero,
  output logic          o_incPC,
  output logic          o_loadPC,
  output logic [IW-1:0] o_selPC,
  output logic [IW-1:0] o_ir,
  output logic [1:0]    o_alu_op,
  output logic          o_acc_we,
  output logic          o_halted,
  output logic          o_busy
);

  localparam logic [3:0] OpLdi = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpJmp = 4'h4;
  localparam logic [3:0] OpJz  = 4'h5;
  localparam logic [3:0] OpHlt = 4'h7;

  localparam logic [1:0] AluPass = 2'b00;
  localparam logic [1:0] AluAdd  = 2'b01;
  localparam logic [1:0] AluSub  = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StHalt
  } state_e;

  state_e        r_state;
  state_e        w_state_next;
  logic [IW-1:0] r_ir;
  logic [3:0]    w_opcode;

  assign w_opcode = r_ir[IW-1:IW-4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StFetch && i_mem_ready) begin
        r_ir <= i_instr;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_incPC      = 1'b0;
    o_loadPC     = 1'b0;
    o_alu_op     = AluPass;
    o_acc_we     = 1'b0;
    o_halted     = 1'b0;
    o_busy       = 1'b0;

    case (r_state)
      StIdle: begin
        if (i_start) w_state_next = StFetch;
      end
      StFetch: begin
        o_busy = 1'b1;
        // PC advances on the same edge that captures the instruction.
        if (i_mem_ready) begin
          o_incPC      = 1'b1;
          w_state_next = StDecode;
        end
      end
      StDecode: begin
        o_busy       = 1'b1;
        w_state_next = StExec;
      end
      StExec: begin
        o_busy       = 1'b1;
        w_state_next = StFetch;
        case (w_opcode)
          OpLdi: begin
            o_acc_we = 1'b1;
            o_alu_op = AluPass;
          end
          OpAdd: begin
            o_acc_we = 1'b1;
            o_alu_op = AluAdd;
          end
          OpSub: begin
            o_acc_we = 1'b1;
            o_alu_op = AluSub;
          end
          OpJmp:   o_loadPC = 1'b1;
          OpJz:    o_loadPC = i_zero;
          OpHlt:   w_state_next = StHalt;
          default: ;  // NOP and unassigned opcodes
        endcase
      end
      StHalt: begin
        o_halted = 1'b1;
        if (i_start) w_state_next = StFetch;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign o_ir    = r_ir;
  assign o_selPC = {{(IW-AW){1'b0}}, r_ir[AW-1:0]};

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic       clk;
  logic       rst_n;
  logic       i_start;
  logic [7:0] i_instr;
  logic       i_mem_ready;
  logic       i_zero;
  logic       o_incPC;
  logic       o_loadPC;
  logic [7:0] o_selPC;
  logic [7:0] o_ir;
  logic [1:0] o_alu_op;
  logic       o_acc_we;
  logic       o_halted;
  logic       o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Environment: instruction memory and a program counter driven by the DUT.
  logic [7:0] imem [16];
  logic [3:0] pc;
  logic       pc_force;
  logic [3:0] pc_val;
  logic       chk_en;

  assign i_instr = imem[pc];

  pc_sequencer #(.IW(8), .AW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_instr    (i_instr),
    .i_mem_ready(i_mem_ready),
    .i_zero     (i_zero),
    .o_incPC    (o_incPC),
    .o_loadPC   (o_loadPC),
    .o_selPC    (o_selPC),
    .o_ir       (o_ir),
    .o_alu_op   (o_alu_op),
    .o_acc_we   (o_acc_we),
    .o_halted   (o_halted),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pc_force)      pc <= pc_val;
    else if (o_loadPC) pc <= o_selPC[3:0];
    else if (o_incPC)  pc <= pc + 4'd1;
  end

  // Reference model: run mode plus position within the 3-step instruction.
  int         m_mode;   // 0 idle, 1 running, 2 halted
  int         m_step;   // 0 fetch, 1 decode, 2 exec
  logic [7:0] m_ir;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0;
      m_step <= 0;
      m_ir   <= 8'h00;
    end else if (m_mode != 1) begin
      if (i_start) begin
        m_mode <= 1;
        m_step <= 0;
      end
    end else if (m_step == 0) begin
      if (i_mem_ready) begin
        m_ir   <= i_instr;
        m_step <= 1;
      end
    end else if (m_step == 1) begin
      m_step <= 2;
    end else begin
      if (m_ir[7:4] == 4'h7) m_mode <= 2;
      else m_step <= 0;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic       e_inc, e_load, e_we, e_exec;
    logic [1:0] e_alu;
    logic [3:0] op;
    #1;
    if (chk_en) begin
      op     = m_ir[7:4];
      e_exec = (m_mode == 1) && (m_step == 2);
      e_inc  = (m_mode == 1) && (m_step == 0) && i_mem_ready;
      e_load = e_exec && ((op == 4'h4) || ((op == 4'h5) && i_zero));
      e_we   = e_exec && (op >= 4'h1) && (op <= 4'h3);
      e_alu  = (e_exec && op == 4'h2) ? 2'b01 : (e_exec && op == 4'h3) ? 2'b10 : 2'b00;
      n_tests++;
      if (o_incPC !== e_inc || o_loadPC !== e_load || o_acc_we !== e_we ||
          o_alu_op !== e_alu || o_ir !== m_ir || o_selPC !== {4'h0, m_ir[3:0]} ||
          o_halted !== (m_mode == 2) || o_busy !== (m_mode == 1) ||
          (o_incPC && o_loadPC)) begin
        n_fail++;
        $display("FAIL model t=%0t got inc=%b load=%b we=%b alu=%b ir=%h sel=%h hlt=%b busy=%b exp inc=%b load=%b we=%b alu=%b ir=%h hlt=%b busy=%b",
                 $time, o_incPC, o_loadPC, o_acc_we, o_alu_op, o_ir, o_selPC, o_halted,
                 o_busy, e_inc, e_load, e_we, e_alu, m_ir, (m_mode == 2), (m_mode == 1));
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    i_start     = 1'b0;
    i_mem_ready = 1'b0;
    i_zero      = 1'b0;
    chk_en      = 1'b0;
    pc_force    = 1'b1;
    pc_val      = 4'd0;
    for (int i = 0; i < 16; i++) imem[i] = 8'h00;
    imem[0] = 8'h15;  // LDI 5
    imem[1] = 8'h23;  // ADD 3
    imem[2] = 8'h70;  // HLT

    repeat (2) @(negedge clk);
    #2;
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_ir", 32'(o_ir), 0);
    chk("rst_inc", 32'(o_incPC), 0);
    chk("rst_sel", 32'(o_selPC), 0);
    chk("rst_halted", 32'(o_halted), 0);
    @(negedge clk);
    rst_n    = 1'b1;
    pc_force = 1'b0;
    chk_en   = 1'b1;

    // LDI 5, ADD 3, HLT
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      i_start     = (c == 0);
      i_mem_ready = 1'b1;
      #2;
      case (c)
        0: chk("p1_idle_busy", 32'(o_busy), 0);
        1: chk("p1_fetch_inc", 32'(o_incPC), 1);
        2: begin
          chk("p1_ir_ldi", 32'(o_ir), 32'h15);
          chk("p1_dec_inc", 32'(o_incPC), 0);
        end
        3: begin
          chk("p1_ldi_we", 32'(o_acc_we), 1);
          chk("p1_ldi_alu", 32'(o_alu_op), 0);
        end
        4: chk("p1_fetch2_inc", 32'(o_incPC), 1);
        6: begin
          chk("p1_add_we", 32'(o_acc_we), 1);
          chk("p1_add_alu", 32'(o_alu_op), 1);
          chk("p1_add_ir", 32'(o_ir), 32'h23);
        end
        9: begin
          chk("p1_hlt_ir", 32'(o_ir), 32'h70);
          chk("p1_hlt_we", 32'(o_acc_we), 0);
        end
        10: begin
          chk("p1_halted", 32'(o_halted), 1);
          chk("p1_halt_busy", 32'(o_busy), 0);
          chk("p1_pc", 32'(pc), 3);
        end
        default: ;
      endcase
    end

    // JMP 0xA at PC 2, JZ 3 (zero=0), JZ 3 (zero=1), HLT with a 4-cycle stall
    @(negedge clk);
    imem[2]  = 8'h4A;
    imem[10] = 8'h53;
    imem[11] = 8'h53;
    imem[3]  = 8'h70;
    pc_force = 1'b1;
    pc_val   = 4'd2;
    @(negedge clk);
    pc_force = 1'b0;
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      i_start     = (c == 0);
      i_mem_ready = !(c >= 10 && c <= 13);
      i_zero      = (c >= 7);
      #2;
      case (c)
        3: begin
          chk("jmp_ir", 32'(o_ir), 32'h4A);
          chk("jmp_load", 32'(o_loadPC), 1);
          chk("jmp_sel", 32'(o_selPC), 32'h0A);
          chk("jmp_inc", 32'(o_incPC), 0);
        end
        4: chk("jmp_pc", 32'(pc), 10);
        6: chk("jz0_load", 32'(o_loadPC), 0);
        7: chk("jz0_pc", 32'(pc), 11);
        9: begin
          chk("jz1_load", 32'(o_loadPC), 1);
          chk("jz1_sel", 32'(o_selPC), 32'h03);
        end
        10: begin
          chk("jz1_pc", 32'(pc), 3);
          chk("stall_inc", 32'(o_incPC), 0);
          chk("stall_busy", 32'(o_busy), 1);
        end
        12: chk("stall_ir", 32'(o_ir), 32'h53);
        14: chk("stall_done_inc", 32'(o_incPC), 1);
        15: chk("stall_ir_hlt", 32'(o_ir), 32'h70);
        16: chk("stall_not_halted", 32'(o_halted), 0);
        17: chk("stall_halted", 32'(o_halted), 1);
        default: ;
      endcase
    end

    // Asynchronous reset in the middle of ADD's EXEC
    imem[4] = 8'h21;
    imem[5] = 8'hC0;
    imem[6] = 8'h70;
    imem[7] = 8'h70;
    i_zero  = 1'b0;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      i_start     = (c == 0);
      i_mem_ready = 1'b1;
      #2;
    end
    chk("arst_pre_we", 32'(o_acc_we), 1);
    chk("arst_pre_alu", 32'(o_alu_op), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(o_acc_we), 0);
    chk("arst_ir", 32'(o_ir), 0);
    chk("arst_busy", 32'(o_busy), 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      chk("arst_no_inc", 32'(o_incPC), 0);
      chk("arst_no_load", 32'(o_loadPC), 0);
    end

    // Opcode 0xC, HLT, restart from HALT
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      i_start     = (c == 0 || c == 7);
      i_mem_ready = 1'b1;
      #2;
      case (c)
        3: begin
          chk("opc_ir", 32'(o_ir), 32'hC0);
          chk("opc_we", 32'(o_acc_we), 0);
          chk("opc_load", 32'(o_loadPC), 0);
        end
        7: chk("opc_halted", 32'(o_halted), 1);
        8: begin
          chk("resume_busy", 32'(o_busy), 1);
          chk("resume_inc", 32'(o_incPC), 1);
          chk("resume_pc", 32'(pc), 7);
        end
        default: ;
      endcase
    end

    // Randomized run against the model
    for (int i = 0; i < 16; i++) imem[i] = {4'($urandom_range(0, 8)), 4'($urandom_range(0, 15))};
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      i_start     = ($urandom_range(0, 3) == 0);
      i_mem_ready = ($urandom_range(0, 3) != 0);
      i_zero      = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        imem[$urandom_range(0, 15)] = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      end
      if ($urandom_range(0, 199) == 0) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
